game_timer_ctrl: RTL

//  Level countdown controller for the gameplay sequencer. It owns the 1 s

---
 rtl/game_timer_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - level countdown timer with 1 s prescaler, BCD digits and low-time blink
// Optional feature macro: TIME_BONUS_EN (adds bonus_pulse, BONUS_SEC and MAX_SEC)

module game_timer_ctrl #(
   parameter int CLK_HZ     = 31_500_000,
   parameter int LEVEL1_SEC = 120,
   parameter int LEVEL2_SEC = 90,
`ifdef TIME_BONUS_EN
   parameter int BONUS_SEC  = 15,
   parameter int MAX_SEC    = 240,
`endif
   parameter int WARN_SEC   = 10
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       game_on,
   input  logic [1:0] level_sel,
   input  logic       timer_restart,
   input  logic       freeze,
`ifdef TIME_BONUS_EN
   input  logic       bonus_pulse,
`endif
   output logic       one_sec_pulse,
   output logic       timer_ended,
   output logic [7:0] time_left,
   output logic [3:0] dig_hund,
   output logic [3:0] dig_tens,
   output logic [3:0] dig_ones,
   output logic       warn_blink
);

   localparam int CNT_W = $clog2(CLK_HZ);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_HZ / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_RUN     = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] presc_cnt;
   logic             half_tick;
   logic             game_on_d;
   logic             game_on_rise;
   logic [7:0]       budget;
   logic [7:0]       tl_bonus;
   logic [7:0]       tl_run;
   logic             dec_en;
   logic             tl_load;
   logic             tl_upd;
   logic             tl_clear;
   logic             warn_window;
   logic [11:0]      bcd;

   // Free-running prescaler, wraps every CLK_HZ cycles regardless of state
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         presc_cnt <= '0;
      end else if (presc_cnt == CNT_LAST) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + 1'b1;
      end
   end

   assign one_sec_pulse = (presc_cnt == CNT_LAST);
   assign half_tick     = (presc_cnt == CNT_HALF) || (presc_cnt == CNT_LAST);

   // Registered copy of game_on for rising-edge detection
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         game_on_d <= 1'b0;
      end else begin
         game_on_d <= game_on;
      end
   end

   assign game_on_rise = game_on && !game_on_d;

   // level 2 has its own budget; every other encoding uses the level 1 budget
   assign budget = (level_sel == 2'd2) ? 8'(LEVEL2_SEC) : 8'(LEVEL1_SEC);

   // Running-time arithmetic: saturating bonus first, then the one-second decrement
   always_comb begin
      tl_bonus = time_left;
`ifdef TIME_BONUS_EN
      if (bonus_pulse) begin
         if (({1'b0, time_left} + 9'(BONUS_SEC)) > 9'(MAX_SEC)) begin
            tl_bonus = 8'(MAX_SEC);
         end else begin
            tl_bonus = time_left + 8'(BONUS_SEC);
         end
      end
`endif
      dec_en = one_sec_pulse && !freeze && (tl_bonus != 8'd0);
      tl_run = dec_en ? (tl_bonus - 8'd1) : tl_bonus;
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; restart outranks a falling game_on, which outranks expiry
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (timer_restart || game_on_rise) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (timer_restart) begin
               state_nxt = S_LOAD;
            end else if (!game_on) begin
               state_nxt = S_IDLE;
            end else if (dec_en && (tl_run == 8'd0)) begin
               state_nxt = S_EXPIRED;
            end
         end
         S_EXPIRED: begin
            if (timer_restart) begin
               state_nxt = S_LOAD;
            end else if (!game_on) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM outputs and time_left update strobes
   always_comb begin
      timer_ended = (state == S_EXPIRED);
      tl_load     = (state == S_LOAD);
      tl_clear    = (state == S_EXPIRED);
      tl_upd      = (state == S_RUN) && !timer_restart && game_on;
      warn_window = (state == S_RUN) && (time_left != 8'd0) &&
                    (time_left <= 8'(WARN_SEC));
   end

   // Remaining-time register; held in IDLE so the HUD keeps the last value
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         time_left <= 8'd0;
      end else if (tl_load) begin
         time_left <= budget;
      end else if (tl_clear) begin
         time_left <= 8'd0;
      end else if (tl_upd) begin
         time_left <= tl_run;
      end
   end

   // Blink phase toggles on each half second inside the warning window
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         warn_blink <= 1'b0;
      end else if (!warn_window) begin
         warn_blink <= 1'b0;
      end else if (half_tick) begin
         warn_blink <= !warn_blink;
      end
   end

   // Double-dabble binary to BCD conversion of time_left
   always_comb begin
      bcd = 12'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bcd[3:0] > 4'd4) begin
            bcd[3:0] = bcd[3:0] + 4'd3;
         end
         if (bcd[7:4] > 4'd4) begin
            bcd[7:4] = bcd[7:4] + 4'd3;
         end
         if (bcd[11:8] > 4'd4) begin
            bcd[11:8] = bcd[11:8] + 4'd3;
         end
         bcd = {bcd[10:0], time_left[i]};
      end
   end

   // Digits are registered, trailing time_left by one cycle
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         dig_hund <= 4'd0;
         dig_tens <= 4'd0;
         dig_ones <= 4'd0;
      end else begin
         dig_hund <= bcd[11:8];
         dig_tens <= bcd[7:4];
         dig_ones <= bcd[3:0];
      end
   end

endmodule
